elevator_dispatcher: RTL and testbench

Consumes the latched per-floor call levels produced by the call-request latch and serves them: it decides direction, steps the car floor by floor, holds the door, and returns a one-cycle clear pulse per served floor to that latch's per-bit clear inputs. It sits between the request latch and the floor display and door drivers, and completes the request handshake: the latch sets a level, and this block clears it.

---
 rtl/elevator_dispatcher_if.sv | 20 ++
 rtl/elevator_dispatcher.sv | 125 ++++++++++++
 tb/tb_elevator_dispatcher.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/elevator_dispatcher_if.sv
// Request/clear handshake and car status between the call latch, the dispatcher and the displays.
interface elevator_dispatcher_if;
    logic       tick;
    logic [7:0] req_level;
    logic [7:0] clr_pulse;
    logic [2:0] floor;
    logic       dir_up;
    logic       moving;
    logic       door_open;

    modport master (
        input  tick, req_level,
        output clr_pulse, floor, dir_up, moving, door_open
    );

    modport slave (
        output tick, req_level,
        input  clr_pulse, floor, dir_up, moving, door_open
    );
endinterface

// File: rtl/elevator_dispatcher.sv
// Elevator car dispatcher: serves latched floor calls and returns one-cycle clear pulses.
// Optional DOOR_REOPEN_EN: a new press at the open floor restarts the door timer in place.
module elevator_dispatcher #(
    parameter int TRAVEL_TICKS = 2,
    parameter int DOOR_TICKS   = 3,
    parameter int CNT_W        = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    elevator_dispatcher_if.master bus
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_UP     = 3'd1;
    localparam logic [2:0] S_DOWN   = 3'd2;
    localparam logic [2:0] S_ARRIVE = 3'd3;
    localparam logic [2:0] S_DOOR   = 3'd4;

    logic [2:0]       r_state, w_state_nx;
    logic [2:0]       r_floor, w_floor_nx;
    logic             r_dir_up, w_dir_nx;
    logic [CNT_W-1:0] r_cnt, w_cnt_nx;
    logic [7:0]       r_clr, w_clr_nx;
    logic             r_moving, r_door;
    logic             w_above, w_below, w_here;
    logic             w_travel_done, w_door_done, w_reopen;

    always_comb begin
        w_above = 1'b0;
        w_below = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (3'(i) > r_floor) w_above = w_above | bus.req_level[i];
            if (3'(i) < r_floor) w_below = w_below | bus.req_level[i];
        end
    end

    assign w_here        = bus.req_level[r_floor];
    assign w_travel_done = bus.tick && (r_cnt == CNT_W'(TRAVEL_TICKS - 1));
    assign w_door_done   = bus.tick && (r_cnt == CNT_W'(DOOR_TICKS - 1));

    // While a clear pulse is outstanding the latch has not yet dropped the bit,
    // so 'here' is only trusted as a fresh press once r_clr is back to zero.
`ifdef DOOR_REOPEN_EN
    assign w_reopen = (r_clr == 8'h00) && w_here;
`else
    assign w_reopen = 1'b0;
`endif

    always_comb begin
        w_state_nx = r_state;
        w_floor_nx = r_floor;
        w_dir_nx   = r_dir_up;
        w_cnt_nx   = bus.tick ? r_cnt + CNT_W'(1) : r_cnt;
        w_clr_nx   = 8'h00;
        case (r_state)
            S_IDLE: begin
                if (w_here)                      w_state_nx = S_DOOR;
                else if (r_dir_up && w_above)    w_state_nx = S_UP;
                else if (!r_dir_up && w_below)   w_state_nx = S_DOWN;
                else if (w_above) begin
                    w_state_nx = S_UP;
                    w_dir_nx   = 1'b1;
                end else if (w_below) begin
                    w_state_nx = S_DOWN;
                    w_dir_nx   = 1'b0;
                end
            end
            S_UP: begin
                if (w_travel_done) begin
                    w_state_nx = S_ARRIVE;
                    w_floor_nx = (r_floor == 3'd7) ? r_floor : r_floor + 3'd1;
                end
            end
            S_DOWN: begin
                if (w_travel_done) begin
                    w_state_nx = S_ARRIVE;
                    w_floor_nx = (r_floor == 3'd0) ? r_floor : r_floor - 3'd1;
                end
            end
            S_ARRIVE: begin
                if (w_here)                      w_state_nx = S_DOOR;
                else if (r_dir_up && w_above)    w_state_nx = S_UP;
                else if (!r_dir_up && w_below)   w_state_nx = S_DOWN;
                else                             w_state_nx = S_IDLE;
            end
            S_DOOR: begin
                if (w_reopen) begin
                    w_cnt_nx = '0;
                    w_clr_nx = 8'h01 << r_floor;
                end else if (w_door_done) begin
                    w_state_nx = S_IDLE;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
        // Every state entry restarts the tick count, so an entry-edge tick is dropped.
        if (w_state_nx != r_state) w_cnt_nx = '0;
        if (w_state_nx == S_DOOR && r_state != S_DOOR) w_clr_nx = 8'h01 << r_floor;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_floor  <= 3'd0;
            r_dir_up <= 1'b1;
            r_cnt    <= '0;
            r_clr    <= 8'h00;
            r_moving <= 1'b0;
            r_door   <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_floor  <= w_floor_nx;
            r_dir_up <= w_dir_nx;
            r_cnt    <= w_cnt_nx;
            r_clr    <= w_clr_nx;
            r_moving <= (w_state_nx == S_UP) || (w_state_nx == S_DOWN);
            r_door   <= (w_state_nx == S_DOOR);
        end
    end

    assign bus.clr_pulse = r_clr;
    assign bus.floor     = r_floor;
    assign bus.dir_up    = r_dir_up;
    assign bus.moving    = r_moving;
    assign bus.door_open = r_door;
endmodule

// File: tb/tb_elevator_dispatcher.sv
// Scoreboard bench: stimulus queues expected clear pulses, a monitor checks each one as it appears.
module tb_elevator_dispatcher;
    typedef struct packed {
        logic [7:0] clr;
        logic [2:0] fl;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [7:0] set_q = 8'h00;
    int n_chk = 0;
    int n_pass = 0;
    int mv_ticks = 0;
    exp_t exp_q[$];

    elevator_dispatcher_if bus ();

    elevator_dispatcher #(.TRAVEL_TICKS(2), .DOOR_TICKS(3), .CNT_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Tick strobe every third cycle, changed just after the rising edge.
    initial begin
        int tc;
        tc = 0;
        bus.tick = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            tc = (tc == 2) ? 0 : tc + 1;
            bus.tick = (tc == 0);
        end
    end

    // Call-request latch model: set by presses, cleared by the dispatcher's pulse.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) bus.req_level <= 8'h00;
        else        bus.req_level <= (bus.req_level & ~bus.clr_pulse) | set_q;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic fail(input string name);
        n_chk++;
        $display("FAIL %s: timed out", name);
    endtask

    task automatic push(input logic [7:0] c, input logic [2:0] f);
        exp_t e;
        e.clr = c;
        e.fl  = f;
        exp_q.push_back(e);
    endtask

    task automatic press(input logic [7:0] m);
        set_q = m;
        @(negedge clk);
        set_q = 8'h00;
    endtask

    task automatic wait_idle(input string name);
        int k;
        for (k = 0; k < 600; k++) begin
            @(negedge clk);
            if (bus.req_level == 8'h00 && !bus.moving && !bus.door_open) break;
        end
        if (k == 600) fail(name);
    endtask

    // Monitor: every clear pulse must match the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus.tick && bus.moving) mv_ticks++;
                if (bus.clr_pulse != 8'h00) begin
                    chk("clr_onehot", 32'($onehot(bus.clr_pulse)), 32'd1);
                    chk("clr_door_open", 32'(bus.door_open), 32'd1);
                    if (exp_q.size() == 0) begin
                        chk("clr_unexpected", 32'(bus.clr_pulse), 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("clr_value", 32'(bus.clr_pulse), 32'(e.clr));
                        chk("clr_floor", 32'(bus.floor), 32'(e.fl));
                    end
                end
            end
        end
    end

    initial begin
        int mv0, dt, pr, k;
        logic prev, pressed;
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_floor", 32'(bus.floor), 32'd0);
        chk("rst_dir_up", 32'(bus.dir_up), 32'd1);
        chk("rst_moving", 32'(bus.moving), 32'd0);
        chk("rst_door", 32'(bus.door_open), 32'd0);
        chk("rst_clr", 32'(bus.clr_pulse), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset mid-UP aborts to floor 0
        press(8'h20);
        for (k = 0; k < 300; k++) begin
            if (bus.floor == 3'd2) break;
            @(negedge clk);
        end
        if (k == 300) fail("reach_floor2");
        chk("midup_moving", 32'(bus.moving || bus.floor == 3'd2), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_floor", 32'(bus.floor), 32'd0);
        chk("midrst_moving", 32'(bus.moving), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Floor 0 -> 3: six travel ticks, one clear
        mv0 = mv_ticks;
        push(8'h08, 3'd3);
        press(8'h08);
        wait_idle("serve_3");
        chk("a_floor", 32'(bus.floor), 32'd3);
        chk("a_travel_ticks", 32'(mv_ticks - mv0), 32'd6);

        // Floor 4 with dir_up: 7 first, then reverse to 1
        push(8'h10, 3'd4);
        press(8'h10);
        wait_idle("serve_4");
        chk("b_dir_at4", 32'(bus.dir_up), 32'd1);
        push(8'h80, 3'd7);
        push(8'h02, 3'd1);
        press(8'h82);
        wait_idle("serve_7_1");
        chk("b_floor", 32'(bus.floor), 32'd1);
        chk("b_dir", 32'(bus.dir_up), 32'd0);

        // Travel 2 -> 6 with floor 4 pressed en route
        push(8'h04, 3'd2);
        press(8'h04);
        wait_idle("serve_2");
        push(8'h10, 3'd4);
        push(8'h40, 3'd6);
        press(8'h40);
        for (k = 0; k < 300; k++) begin
            if (bus.floor == 3'd3) break;
            @(negedge clk);
        end
        if (k == 300) fail("reach_floor3");
        press(8'h10);
        wait_idle("serve_4_6");
        chk("c_floor", 32'(bus.floor), 32'd6);

        // Floor 7, then a call at 7 opens the door without moving
        push(8'h80, 3'd7);
        press(8'h80);
        wait_idle("serve_7");
        mv0 = mv_ticks;
        push(8'h80, 3'd7);
        press(8'h80);
        wait_idle("serve_7_here");
        chk("d_floor", 32'(bus.floor), 32'd7);
        chk("d_no_move", 32'(mv_ticks - mv0), 32'd0);

        // Press the open floor after the second door tick
        push(8'h80, 3'd7);
        push(8'h80, 3'd7);
        press(8'h80);
        dt = 0;
        pr = 0;
        prev = 1'b0;
        pressed = 1'b0;
        for (k = 0; k < 400; k++) begin
            if (bus.door_open && !prev) pr++;
            prev = bus.door_open;
            if (bus.tick && bus.door_open) dt++;
            if (pressed && bus.req_level == 8'h00 && !bus.door_open && !bus.moving) break;
            if (dt == 2 && !pressed) begin
                pressed = 1'b1;
                set_q = 8'h80;
            end
            @(negedge clk);
            set_q = 8'h00;
        end
        if (k == 400) fail("reopen_done");
`ifdef DOOR_REOPEN_EN
        chk("reopen_door_ticks", 32'(dt), 32'd5);
        chk("reopen_door_rises", 32'(pr), 32'd1);
`else
        chk("reopen_door_ticks", 32'(dt), 32'd6);
        chk("reopen_door_rises", 32'(pr), 32'd2);
`endif
        repeat (4) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        chk("end_floor", 32'(bus.floor), 32'd7);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
